// File: rtl/zoom_pkg.sv
// Shared constants and encodings for the zoom sequencer family.
// Window offsets place the 160x120 zoom region in the centre of a 320x240 frame.
package zoom_pkg;

    localparam int LARGURA_PADRAO = 320;
    localparam int ALTURA_PADRAO  = 240;

    localparam int DATA_W   = 8;
    localparam int LINHA_W  = 8;
    localparam int COLUNA_W = 9;

    localparam logic [LINHA_W-1:0]  OFS_LINHA         = 8'd60;
    localparam logic [COLUNA_W-1:0] OFS_COLUNA        = 9'd80;
    localparam logic [LINHA_W-1:0]  FIM_JANELA_LINHA  = 8'd180;
    localparam logic [COLUNA_W-1:0] FIM_JANELA_COLUNA = 9'd240;

    typedef enum logic [1:0] {
        MODO_COPIA     = 2'b00,
        MODO_ZOOM_IN   = 2'b01,
        MODO_ZOOM_OUT  = 2'b10,
        MODO_RESERVADO = 2'b11
    } modo_t;

    typedef enum logic [1:0] {
        OCIOSO  = 2'b00,
        VARRE   = 2'b01,
        ESVAZIA = 2'b10,
        FIM     = 2'b11
    } estado_t;

endpackage

// File: rtl/controlador_zoom_if.sv
// Memory-side bus of the zoom sequencer: source read port and destination write port.
interface controlador_zoom_if;
    import zoom_pkg::*;

    logic [LINHA_W-1:0]  src_linha;
    logic [COLUNA_W-1:0] src_coluna;
    logic [DATA_W-1:0]   src_byte;
    logic [LINHA_W-1:0]  dst_linha;
    logic [COLUNA_W-1:0] dst_coluna;
    logic                dst_escrever;
    logic [DATA_W-1:0]   dst_byte;

    modport master (
        output src_linha, src_coluna,
        input  src_byte,
        output dst_linha, dst_coluna, dst_escrever, dst_byte
    );

    modport slave (
        input  src_linha, src_coluna,
        output src_byte,
        input  dst_linha, dst_coluna, dst_escrever, dst_byte
    );

endinterface

// File: rtl/controlador_zoom_mapeador.sv
// Combinational destination->source address mapping for copy / zoom-in / zoom-out.
// Zoom-out pixels outside the central window are flagged so the writer blanks them.
module mapeador_endereco
    import zoom_pkg::*;
(
    input  modo_t               modo,
    input  logic [LINHA_W-1:0]  linha,
    input  logic [COLUNA_W-1:0] coluna,
    output logic [LINHA_W-1:0]  src_linha,
    output logic [COLUNA_W-1:0] src_coluna,
    output logic                fora
);

    logic dentro;

    assign dentro = (linha >= OFS_LINHA) && (linha < FIM_JANELA_LINHA) &&
                    (coluna >= OFS_COLUNA) && (coluna < FIM_JANELA_COLUNA);

    always_comb begin
        src_linha  = linha;
        src_coluna = coluna;
        fora       = 1'b0;
        case (modo)
            MODO_ZOOM_IN: begin
                src_linha  = OFS_LINHA + (linha >> 1);
                src_coluna = OFS_COLUNA + (coluna >> 1);
            end
            MODO_ZOOM_OUT: begin
                if (dentro) begin
                    src_linha  = (linha - OFS_LINHA) << 1;
                    src_coluna = (coluna - OFS_COLUNA) << 1;
                end else begin
                    src_linha  = '0;
                    src_coluna = '0;
                    fora       = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/controlador_zoom.sv
// Zoom pass sequencer: raster-scans the destination, reads the mapped source pixel
// and writes it one clock later, one pixel per clock with no bubbles.
module controlador_zoom
    import zoom_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int ALTURA  = ALTURA_PADRAO
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [1:0]         modo,
    output logic               ocupado,
    output logic               concluido,
    controlador_zoom_if.master mem
);

    localparam logic [LINHA_W-1:0]  LINHA_ULT  = LINHA_W'(ALTURA - 1);
    localparam logic [COLUNA_W-1:0] COLUNA_ULT = COLUNA_W'(LARGURA - 1);

    estado_t             estado;
    modo_t               modo_q;
    logic [LINHA_W-1:0]  linha_p0;
    logic [COLUNA_W-1:0] coluna_p0;
    logic                vld_p0;
    logic [LINHA_W-1:0]  map_linha;
    logic [COLUNA_W-1:0] map_coluna;
    logic                map_fora;

    logic                vld_p1;
    logic [LINHA_W-1:0]  dst_linha_p1;
    logic [COLUNA_W-1:0] dst_coluna_p1;
    logic                fora_p1;

    // Stage 0: source address straight from the scan counters
    assign vld_p0 = (estado == VARRE);

    mapeador_endereco u_mapeador (
        .modo       (modo_q),
        .linha      (linha_p0),
        .coluna     (coluna_p0),
        .src_linha  (map_linha),
        .src_coluna (map_coluna),
        .fora       (map_fora)
    );

    assign mem.src_linha  = vld_p0 ? map_linha  : '0;
    assign mem.src_coluna = vld_p0 ? map_coluna : '0;

    // Stage 1: source data arrives now, aligned with the registered destination address
    assign mem.dst_linha    = dst_linha_p1;
    assign mem.dst_coluna   = dst_coluna_p1;
    assign mem.dst_escrever = vld_p1;
    assign mem.dst_byte     = fora_p1 ? '0 : mem.src_byte;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado        <= OCIOSO;
            modo_q        <= MODO_COPIA;
            linha_p0      <= '0;
            coluna_p0     <= '0;
            ocupado       <= 1'b0;
            concluido     <= 1'b0;
            vld_p1        <= 1'b0;
            dst_linha_p1  <= '0;
            dst_coluna_p1 <= '0;
            fora_p1       <= 1'b0;
        end else begin
            concluido     <= 1'b0;
            vld_p1        <= vld_p0;
            dst_linha_p1  <= linha_p0;
            dst_coluna_p1 <= coluna_p0;
            fora_p1       <= map_fora;

            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        estado    <= VARRE;
                        modo_q    <= modo_t'(modo);
                        linha_p0  <= '0;
                        coluna_p0 <= '0;
                        ocupado   <= 1'b1;
                    end
                end
                VARRE: begin
                    if (coluna_p0 == COLUNA_ULT) begin
                        coluna_p0 <= '0;
                        if (linha_p0 == LINHA_ULT) begin
                            // counters return to 0 so the idle address bus is quiet
                            linha_p0 <= '0;
                            estado   <= ESVAZIA;
                        end else begin
                            linha_p0 <= linha_p0 + 1'b1;
                        end
                    end else begin
                        coluna_p0 <= coluna_p0 + 1'b1;
                    end
                end
                ESVAZIA: begin
                    estado    <= FIM;
                    ocupado   <= 1'b0;
                    concluido <= 1'b1;
                end
                default: begin
                    estado <= OCIOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_zoom.sv
// Bench for controlador_zoom: three instances (copy, zoom-in, zoom-out) run one full
// pass side by side; a monitor pops expected writes from per-instance scoreboards.
module tb_controlador_zoom;
    import zoom_pkg::*;

    localparam int NPIX = 76800;

    typedef struct packed {
        logic [7:0] l;
        logic [8:0] c;
        logic [7:0] b;
    } px_t;

    typedef struct {
        int k;
        int l;
        int c;
        int v;
    } ponto_t;

    logic       clock = 1'b0;
    logic [2:0] reset;
    logic [2:0] iniciar;
    logic [1:0] modo [3];
    logic [2:0] ocupado;
    logic [2:0] concluido;

    controlador_zoom_if bus0 ();
    controlador_zoom_if bus1 ();
    controlador_zoom_if bus2 ();

    controlador_zoom dut0 (
        .clock(clock), .reset(reset[0]), .iniciar(iniciar[0]), .modo(modo[0]),
        .ocupado(ocupado[0]), .concluido(concluido[0]), .mem(bus0)
    );
    controlador_zoom dut1 (
        .clock(clock), .reset(reset[1]), .iniciar(iniciar[1]), .modo(modo[1]),
        .ocupado(ocupado[1]), .concluido(concluido[1]), .mem(bus1)
    );
    controlador_zoom dut2 (
        .clock(clock), .reset(reset[2]), .iniciar(iniciar[2]), .modo(modo[2]),
        .ocupado(ocupado[2]), .concluido(concluido[2]), .mem(bus2)
    );

    always #5 clock = ~clock;

    // Source framebuffers: synchronous read of src(l,c) = (l+c) mod 256
    always @(posedge clock) bus0.src_byte <= 8'(bus0.src_linha + bus0.src_coluna);
    always @(posedge clock) bus1.src_byte <= 8'(bus1.src_linha + bus1.src_coluna);
    always @(posedge clock) bus2.src_byte <= 8'(bus2.src_linha + bus2.src_coluna);

    logic [2:0] escr;
    logic [7:0] dl [3];
    logic [8:0] dc [3];
    logic [7:0] db [3];
    logic [7:0] sl [3];
    logic [8:0] sc [3];

    assign escr  = {bus2.dst_escrever, bus1.dst_escrever, bus0.dst_escrever};
    assign dl[0] = bus0.dst_linha;   assign dl[1] = bus1.dst_linha;   assign dl[2] = bus2.dst_linha;
    assign dc[0] = bus0.dst_coluna;  assign dc[1] = bus1.dst_coluna;  assign dc[2] = bus2.dst_coluna;
    assign db[0] = bus0.dst_byte;    assign db[1] = bus1.dst_byte;    assign db[2] = bus2.dst_byte;
    assign sl[0] = bus0.src_linha;   assign sl[1] = bus1.src_linha;   assign sl[2] = bus2.src_linha;
    assign sc[0] = bus0.src_coluna;  assign sc[1] = bus1.src_coluna;  assign sc[2] = bus2.src_coluna;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    px_t        sb [3][$];
    int         wr_cnt [3];
    int         first_cyc [3];
    int         last_cyc [3];
    int         conc_cnt [3];
    int         conc_cyc [3];
    int         ocup_cnt [3];
    int         ocup_last [3];
    int         first_l [3];
    int         first_c [3];
    logic [7:0] img [3][NPIX];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic verifica(input string nome, input int atual, input int exigido);
        checks++;
        if (atual !== exigido) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nome, atual, exigido);
        end
    endtask

    // Reference image: instance 0 copies, 1 zooms in, 2 zooms out
    function automatic logic [7:0] esperado(input int k, input int l, input int c);
        int fl;
        int fc;
        case (k)
            1: begin
                fl = 60 + l / 2;
                fc = 80 + c / 2;
            end
            2: begin
                if (l < 60 || l >= 180 || c < 80 || c >= 240) return 8'h00;
                fl = 2 * (l - 60);
                fc = 2 * (c - 80);
            end
            default: begin
                fl = l;
                fc = c;
            end
        endcase
        return 8'((fl + fc) % 256);
    endfunction

    task automatic carregar(input int k);
        px_t p;
        sb[k].delete();
        for (int l = 0; l < 240; l++) begin
            for (int c = 0; c < 320; c++) begin
                p.l = 8'(l);
                p.c = 9'(c);
                p.b = esperado(k, l, c);
                sb[k].push_back(p);
            end
        end
    endtask

    task automatic limpa_stats(input int k);
        wr_cnt[k]    = 0;
        first_cyc[k] = -1;
        last_cyc[k]  = -1;
        conc_cnt[k]  = 0;
        conc_cyc[k]  = -1;
        ocup_cnt[k]  = 0;
        ocup_last[k] = -1;
        first_l[k]   = -1;
        first_c[k]   = -1;
    endtask

    // Monitor: every destination write is compared with the head of its scoreboard
    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < 3; k++) begin
                px_t e;
                int  idx;
                if (escr[k]) begin
                    wr_cnt[k]++;
                    if (wr_cnt[k] == 1) begin
                        first_cyc[k] = cyc;
                        first_l[k]   = int'(dl[k]);
                        first_c[k]   = int'(dc[k]);
                    end
                    last_cyc[k] = cyc;
                    idx = int'(dl[k]) * 320 + int'(dc[k]);
                    if (idx < NPIX) img[k][idx] = db[k];
                    checks++;
                    if (sb[k].size() == 0) begin
                        errors++;
                        $display("FAIL extra_write[%0d]: got (%0d,%0d)=%0d, expected no write",
                                 k, dl[k], dc[k], db[k]);
                    end else begin
                        e = sb[k].pop_front();
                        if (dl[k] !== e.l || dc[k] !== e.c || db[k] !== e.b) begin
                            errors++;
                            $display("FAIL pixel[%0d]: got (%0d,%0d)=%0d, expected (%0d,%0d)=%0d",
                                     k, dl[k], dc[k], db[k], e.l, e.c, e.b);
                        end
                    end
                end
                if (concluido[k]) begin
                    conc_cnt[k]++;
                    conc_cyc[k] = cyc;
                end
                if (ocupado[k]) begin
                    ocup_cnt[k]++;
                    ocup_last[k] = cyc;
                end
            end
        end
    end

    initial begin
        int     espera;
        int     t0;
        ponto_t pontos [14];

        pontos = '{
            '{1, 0, 0, 140}, '{1, 0, 1, 140}, '{1, 1, 0, 140}, '{1, 1, 1, 140},
            '{1, 239, 319, 162}, '{1, 2, 4, 143},
            '{2, 60, 80, 0}, '{2, 179, 239, 44}, '{2, 0, 0, 0}, '{2, 59, 80, 0},
            '{2, 60, 240, 0}, '{2, 61, 81, 4},
            '{0, 100, 200, 44}, '{0, 239, 319, 46}
        };
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NPIX; i++) img[k][i] = 8'hA5;
            limpa_stats(k);
            modo[k] = 2'b00;
        end
        reset   = 3'b111;
        iniciar = 3'b000;

        // Reset state
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            verifica($sformatf("reset_ocupado[%0d]", k), int'(ocupado[k]), 0);
            verifica($sformatf("reset_concluido[%0d]", k), int'(concluido[k]), 0);
            verifica($sformatf("reset_escrever[%0d]", k), int'(escr[k]), 0);
            verifica($sformatf("reset_dst_addr[%0d]", k), int'(dl[k]) + int'(dc[k]), 0);
            verifica($sformatf("reset_src_addr[%0d]", k), int'(sl[k]) + int'(sc[k]), 0);
        end
        reset = 3'b000;
        @(negedge clock);

        // Abort a copy pass on instance 0 while dst (3,40) is being written
        carregar(0);
        modo[0]    = 2'b00;
        iniciar[0] = 1'b1;
        @(negedge clock);
        iniciar[0] = 1'b0;
        espera = 0;
        while (!(escr[0] && dl[0] == 8'd3 && dc[0] == 9'd40) && espera < 2000) begin
            @(negedge clock);
            espera++;
        end
        verifica("abort_point_reached", int'(espera < 2000), 1);
        reset[0] = 1'b1;
        @(negedge clock);
        reset[0] = 1'b0;
        verifica("abort_escrever", int'(escr[0]), 0);
        verifica("abort_ocupado", int'(ocupado[0]), 0);
        verifica("abort_writes", wr_cnt[0], 3 * 320 + 41);
        verifica("abort_pending", sb[0].size(), NPIX - (3 * 320 + 41));
        repeat (4) @(negedge clock);
        verifica("abort_no_concluido", conc_cnt[0], 0);
        verifica("abort_still_idle", int'(ocupado[0]) + int'(escr[0]), 0);

        // Full pass on all three instances at once
        for (int k = 0; k < 3; k++) begin
            carregar(k);
            limpa_stats(k);
        end
        modo[0] = 2'b00;
        modo[1] = 2'b01;
        modo[2] = 2'b10;
        iniciar = 3'b111;
        t0      = cyc;
        while (cyc < t0 + 76802) begin
            @(negedge clock);
            iniciar = (cyc == t0 + 5) ? 3'b111 : 3'b000;
            if (cyc == t0 + 100) begin
                for (int k = 0; k < 3; k++) modo[k] = modo[k] ^ 2'b11;
            end
        end
        iniciar = 3'b111;
        @(negedge clock);
        iniciar = 3'b000;
        repeat (4) @(negedge clock);

        for (int k = 0; k < 3; k++) begin
            verifica($sformatf("first_write_cycle[%0d]", k), first_cyc[k] - t0, 2);
            verifica($sformatf("first_write_addr[%0d]", k), first_l[k] * 1000 + first_c[k], 0);
            verifica($sformatf("write_count[%0d]", k), wr_cnt[k], NPIX);
            verifica($sformatf("last_write_cycle[%0d]", k), last_cyc[k] - t0, 76801);
            verifica($sformatf("concluido_count[%0d]", k), conc_cnt[k], 1);
            verifica($sformatf("concluido_cycle[%0d]", k), conc_cyc[k] - t0, 76802);
            verifica($sformatf("ocupado_cycles[%0d]", k), ocup_cnt[k], 76801);
            verifica($sformatf("ocupado_last[%0d]", k), ocup_last[k] - t0, 76801);
            verifica($sformatf("scoreboard_drained[%0d]", k), sb[k].size(), 0);
            verifica($sformatf("idle_after_pass[%0d]", k), int'(ocupado[k]) + int'(escr[k]), 0);
        end
        foreach (pontos[i]) begin
            verifica($sformatf("pixel_inst%0d_(%0d,%0d)", pontos[i].k, pontos[i].l, pontos[i].c),
                     int'(img[pontos[i].k][pontos[i].l * 320 + pontos[i].c]), pontos[i].v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
